// File: rtl/multicycle_control.sv
// Multicycle MIPS-style control unit: Moore FSM that sequences
// fetch/decode/execute for R-type, lw, sw, beq and j, and counts retired
// instructions.
//
// Ports:
//   clk                      rising-edge clock
//   rst_n                    async active-low reset
//   op[5:0]                  opcode from the instruction register
//   pcwrite .. regdst        1-bit datapath strobes and selects
//   alusrcb[1:0]             ALU B-operand select
//   pcsource[1:0]            next-PC select
//   aluop1, aluop0           ALU control decoder selector
//   state[3:0]               current state code
//   illegal                  unknown opcode seen in DECODE
//   icount[15:0]             retired-instruction count (wraps)
module multicycle_control (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [5:0]  op,
    output logic        pcwrite,
    output logic        pcwritecond,
    output logic        iord,
    output logic        memread,
    output logic        memwrite,
    output logic        memtoreg,
    output logic        irwrite,
    output logic        alusrca,
    output logic        regwrite,
    output logic        regdst,
    output logic [1:0]  alusrcb,
    output logic [1:0]  pcsource,
    output logic        aluop1,
    output logic        aluop0,
    output logic [3:0]  state,
    output logic        illegal,
    output logic [15:0] icount
);

    localparam int unsigned CNT_W = 16;

    localparam logic [5:0] OP_R   = 6'b000000;
    localparam logic [5:0] OP_LW  = 6'b100011;
    localparam logic [5:0] OP_SW  = 6'b101011;
    localparam logic [5:0] OP_BEQ = 6'b000100;
    localparam logic [5:0] OP_J   = 6'b000010;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_RWB    = 4'd7,
        S_BEQ    = 4'd8,
        S_JUMP   = 4'd9
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   icount_q, icount_d;
    // Low from reset until the first edge after release; holds FETCH with
    // strobes off so the first cycle after that edge is a full FETCH.
    logic               run_q;
    logic               op_known;

    assign op_known = (op == OP_R) || (op == OP_LW) || (op == OP_SW) ||
                      (op == OP_BEQ) || (op == OP_J);

    // State, counter and run-enable registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_FETCH;
            icount_q <= '0;
            run_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            icount_q <= icount_d;
            run_q    <= 1'b1;
        end
    end

    // Next-state and retire counting
    always_comb begin
        state_d  = state_q;
        icount_d = icount_q;
        if (!run_q) begin
            state_d = S_FETCH;
        end else begin
            unique case (state_q)
                S_FETCH:  state_d = S_DECODE;
                S_DECODE: begin
                    if (op == OP_LW || op == OP_SW) state_d = S_MEMADR;
                    else if (op == OP_R)            state_d = S_EXEC;
                    else if (op == OP_BEQ)          state_d = S_BEQ;
                    else if (op == OP_J)            state_d = S_JUMP;
                    else                            state_d = S_FETCH;
                end
                // Anything but lw here falls to the store path (no reg write).
                S_MEMADR: state_d = (op == OP_LW) ? S_MEMRD : S_MEMWR;
                S_MEMRD:  state_d = S_MEMWB;
                S_EXEC:   state_d = S_RWB;
                S_MEMWB, S_MEMWR, S_RWB, S_BEQ, S_JUMP: begin
                    state_d  = S_FETCH;
                    icount_d = icount_q + CNT_W'(1);
                end
                default:  state_d = S_FETCH;
            endcase
        end
    end

    // Moore output decode
    always_comb begin
        pcwrite     = 1'b0;
        pcwritecond = 1'b0;
        iord        = 1'b0;
        memread     = 1'b0;
        memwrite    = 1'b0;
        memtoreg    = 1'b0;
        irwrite     = 1'b0;
        alusrca     = 1'b0;
        regwrite    = 1'b0;
        regdst      = 1'b0;
        alusrcb     = 2'b00;
        pcsource    = 2'b00;
        aluop1      = 1'b0;
        aluop0      = 1'b0;
        illegal     = 1'b0;
        unique case (state_q)
            S_FETCH: begin
                memread = 1'b1;
                irwrite = 1'b1;
                pcwrite = 1'b1;
                alusrcb = 2'b01;
            end
            S_DECODE: begin
                alusrcb = 2'b11;
                illegal = !op_known;
            end
            S_MEMADR: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
            end
            S_MEMRD: begin
                memread = 1'b1;
                iord    = 1'b1;
            end
            S_MEMWB: begin
                regwrite = 1'b1;
                memtoreg = 1'b1;
            end
            S_MEMWR: begin
                memwrite = 1'b1;
                iord     = 1'b1;
            end
            S_EXEC: begin
                alusrca = 1'b1;
                aluop1  = 1'b1;
            end
            S_RWB: begin
                regwrite = 1'b1;
                regdst   = 1'b1;
            end
            S_BEQ: begin
                alusrca     = 1'b1;
                aluop0      = 1'b1;
                pcwritecond = 1'b1;
                pcsource    = 2'b01;
            end
            S_JUMP: begin
                pcwrite  = 1'b1;
                pcsource = 2'b10;
            end
            default: ;
        endcase
        // Strobes stay off in reset and until the first post-reset edge.
        if (!run_q) begin
            pcwrite     = 1'b0;
            pcwritecond = 1'b0;
            memread     = 1'b0;
            memwrite    = 1'b0;
            irwrite     = 1'b0;
            regwrite    = 1'b0;
            illegal     = 1'b0;
        end
    end

    assign state  = state_q;
    assign icount = icount_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: walks each instruction class
// through its state sequence, checking state, all control outputs, illegal
// and icount at every cycle, plus mid-instruction reset and icount wrap.
module tb_multicycle_control;

    logic        clk;
    logic        rst_n;
    logic [5:0]  op;
    logic        pcwrite, pcwritecond, iord, memread, memwrite, memtoreg;
    logic        irwrite, alusrca, regwrite, regdst, aluop1, aluop0;
    logic [1:0]  alusrcb, pcsource;
    logic [3:0]  state;
    logic        illegal;
    logic [15:0] icount;
    logic [15:0] ctrl;

    int n_cmp  = 0;
    int n_fail = 0;

    localparam logic [5:0] OP_R   = 6'b000000;
    localparam logic [5:0] OP_LW  = 6'b100011;
    localparam logic [5:0] OP_SW  = 6'b101011;
    localparam logic [5:0] OP_BEQ = 6'b000100;
    localparam logic [5:0] OP_J   = 6'b000010;
    localparam logic [5:0] OP_BAD = 6'b111111;

    // {pcwrite,pcwritecond,iord,memread,memwrite,memtoreg,irwrite,alusrca,
    //  regwrite,regdst,alusrcb[1:0],pcsource[1:0],aluop1,aluop0}
    localparam logic [15:0] C_RESET = 16'h0010;

    multicycle_control dut (
        .clk(clk), .rst_n(rst_n), .op(op),
        .pcwrite(pcwrite), .pcwritecond(pcwritecond), .iord(iord),
        .memread(memread), .memwrite(memwrite), .memtoreg(memtoreg),
        .irwrite(irwrite), .alusrca(alusrca), .regwrite(regwrite),
        .regdst(regdst), .alusrcb(alusrcb), .pcsource(pcsource),
        .aluop1(aluop1), .aluop0(aluop0), .state(state),
        .illegal(illegal), .icount(icount)
    );

    assign ctrl = {pcwrite, pcwritecond, iord, memread, memwrite, memtoreg,
                   irwrite, alusrca, regwrite, regdst, alusrcb, pcsource,
                   aluop1, aluop0};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hand-derived control word per state
    function automatic logic [15:0] exp_ctrl(input logic [3:0] s);
        case (s)
            4'd0:    return 16'h9210;
            4'd1:    return 16'h0030;
            4'd2:    return 16'h0120;
            4'd3:    return 16'h3000;
            4'd4:    return 16'h0480;
            4'd5:    return 16'h2800;
            4'd6:    return 16'h0102;
            4'd7:    return 16'h00C0;
            4'd8:    return 16'h4105;
            4'd9:    return 16'h8008;
            default: return 16'h0000;
        endcase
    endfunction

    task automatic cmp16(input string tag, input logic [15:0] got, input logic [15:0] want);
        n_cmp++;
        assert (got === want) else begin
            n_fail++;
            $error("FAIL %s: got 0x%04h want 0x%04h", tag, got, want);
        end
    endtask

    // Check all observable outputs against an expected state
    task automatic check(input string tag, input logic [3:0] st, input logic [15:0] cnt,
                         input logic ill);
        cmp16({tag, ".state"}, 16'(state), 16'(st));
        cmp16({tag, ".ctrl"}, ctrl, exp_ctrl(st));
        cmp16({tag, ".illegal"}, 16'(illegal), 16'(ill));
        cmp16({tag, ".icount"}, icount, cnt);
    endtask

    task automatic visit(input string tag, input logic [3:0] st, input logic [15:0] cnt,
                         input logic ill = 1'b0);
        check(tag, st, cnt, ill);
        @(negedge clk);
    endtask

    task automatic check_reset(input string tag);
        cmp16({tag, ".state"}, 16'(state), 16'd0);
        cmp16({tag, ".ctrl"}, ctrl, C_RESET);
        cmp16({tag, ".illegal"}, 16'(illegal), 16'd0);
        cmp16({tag, ".icount"}, icount, 16'd0);
    endtask

    initial begin
        rst_n = 1'b0;
        op    = OP_LW;
        repeat (3) @(negedge clk);
        check_reset("rst");
        rst_n = 1'b1;
        @(negedge clk);

        // lw
        visit("lw.F", 4'd0, 16'd0);
        visit("lw.D", 4'd1, 16'd0);
        visit("lw.MA", 4'd2, 16'd0);
        visit("lw.MR", 4'd3, 16'd0);
        visit("lw.MW", 4'd4, 16'd0);
        // sw then R-type
        op = OP_SW;
        visit("sw.F", 4'd0, 16'd1);
        visit("sw.D", 4'd1, 16'd1);
        visit("sw.MA", 4'd2, 16'd1);
        visit("sw.MWR", 4'd5, 16'd1);
        op = OP_R;
        visit("r.F", 4'd0, 16'd2);
        visit("r.D", 4'd1, 16'd2);
        visit("r.EX", 4'd6, 16'd2);
        visit("r.RWB", 4'd7, 16'd2);
        // beq then j
        op = OP_BEQ;
        visit("beq.F", 4'd0, 16'd3);
        visit("beq.D", 4'd1, 16'd3);
        visit("beq.B", 4'd8, 16'd3);
        op = OP_J;
        visit("j.F", 4'd0, 16'd4);
        visit("j.D", 4'd1, 16'd4);
        visit("j.J", 4'd9, 16'd4);
        // unknown opcode: two cycles, flagged, not counted
        op = OP_BAD;
        visit("bad.F", 4'd0, 16'd5);
        visit("bad.D", 4'd1, 16'd5, 1'b1);
        // lw whose op changes to R-type in MEMADR goes the store path
        op = OP_LW;
        visit("chg.F", 4'd0, 16'd5);
        visit("chg.D", 4'd1, 16'd5);
        op = OP_R;
        visit("chg.MA", 4'd2, 16'd5);
        visit("chg.MWR", 4'd5, 16'd5);
        // lw interrupted by reset in MEMRD
        op = OP_LW;
        visit("ir.F", 4'd0, 16'd6);
        visit("ir.D", 4'd1, 16'd6);
        visit("ir.MA", 4'd2, 16'd6);
        check("ir.MR", 4'd3, 16'd6, 1'b0);
        #2 rst_n = 1'b0;
        #1 check_reset("ir.async");
        @(negedge clk);
        check_reset("ir.hold");
        rst_n = 1'b1;
        @(negedge clk);
        // icount wrap via 65536 jumps
        op = OP_J;
        visit("wr.F0", 4'd0, 16'd0);
        repeat (3 * 65535 - 1) @(negedge clk);
        visit("wr.Fmax", 4'd0, 16'hFFFF);
        visit("wr.D", 4'd1, 16'hFFFF);
        visit("wr.J", 4'd9, 16'hFFFF);
        visit("wr.F", 4'd0, 16'h0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 SHALL have port: clk  input  1  rising-edge clock; the only clock.
REQ-002 SHALL have port: rst_n  input  1  reset; asynchronous, active-low.
REQ-003 SHALL have port: op  input  6  opcode from the instruction register; stable from the DECODE cycle onward.
REQ-004 SHALL have outputs, each 1 bit: pcwrite, pcwritecond, iord, memread, memwrite, memtoreg, irwrite, alusrca, regwrite, regdst.
REQ-005 SHALL have outputs: alusrcb  output  2  ALU B-operand select; pcsource  output  2  next-PC select.
REQ-006 SHALL have outputs: aluop1, aluop0  output  1 each; these feed the ALU control decoder (00 = add, 01 = subtract, 10 = R-type funct decode).
REQ-007 SHALL have outputs: state  output  4  current state code; illegal  output  1  unknown-opcode flag; icount  output  16  count of retired instructions.

Function
REQ-008 SHALL be a Moore FSM with these state codes: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, RWB=7, BEQ=8, JUMP=9.
REQ-009 SHALL decode op as follows: 000000 R-type, 100011 lw, 101011 sw, 000100 beq, 000010 j; every other value is unknown.
REQ-010 SHALL use these transitions: FETCH->DECODE always.
 - DECODE: lw/sw->MEMADR, R->EXEC, beq->BEQ, j->JUMP, unknown->FETCH.
 - MEMADR: lw->MEMRD, sw->MEMWR; op is re-sampled here.
 - MEMRD->MEMWB, then MEMWB, MEMWR, RWB, BEQ and JUMP each ->FETCH; EXEC->RWB.
REQ-011 SHALL drive every output not listed for a state to 0, including the mux selects.
REQ-012 SHALL drive in FETCH: memread=1, irwrite=1, pcwrite=1, alusrcb=01, aluop=00, pcsource=00, iord=0, alusrca=0.
REQ-013 SHALL drive in DECODE: alusrcb=11, aluop=00 (branch-target precompute).
REQ-014 SHALL drive in MEMADR: alusrca=1, alusrcb=10, aluop=00.
REQ-015 SHALL drive in MEMRD: memread=1, iord=1. In MEMWB: regwrite=1, memtoreg=1, regdst=0.
REQ-016 SHALL drive in MEMWR: memwrite=1, iord=1.
REQ-017 SHALL drive in EXEC: alusrca=1, alusrcb=00, aluop=10. In RWB: regwrite=1, regdst=1, memtoreg=0.
REQ-018 SHALL drive in BEQ: alusrca=1, alusrcb=00, aluop=01, pcwritecond=1, pcsource=01.
REQ-019 SHALL drive in JUMP: pcwrite=1, pcsource=10.
REQ-020 SHALL assert illegal combinationally only while state=DECODE and op is unknown; one cycle per occurrence.
REQ-021 SHALL make the cycles-per-instruction: lw 5, sw 4, R-type 4, beq 3, j 3; an unknown op takes 2 cycles.
REQ-022 SHALL increment icount by 1 on each transition from MEMWB, MEMWR, RWB, BEQ or JUMP into FETCH.
REQ-023 SHALL NOT increment icount for an unknown-op return to FETCH.
REQ-024 SHALL wrap icount from 0xFFFF to 0x0000 with no flag.
REQ-025 SHALL treat an op change in MEMADR to a value other than lw/sw as sw, so that no memory read or register write occurs.

Reset
REQ-026 SHALL, while rst_n=0, asynchronously force state=FETCH and icount=0.
REQ-027 SHALL, while rst_n=0, force pcwrite, pcwritecond, memread, memwrite, irwrite, regwrite and illegal to 0; the mux selects take their FETCH values.
REQ-028 SHALL abandon any in-flight instruction when rst_n is asserted mid-instruction, with no partial write strobes after assertion.
REQ-029 SHALL resume at the first rising clk edge after rst_n deasserts; that cycle is a full FETCH with the REQ-012 outputs.

Verification
REQ-030 SHALL be verified with lw (op=100011) from reset: states 0,1,2,3,4,0 -> memread high in FETCH and MEMRD, regwrite+memtoreg in MEMWB only, icount 0->1 on return to FETCH.
REQ-031 SHALL be verified with sw then R-type back-to-back: states 0,1,2,5,0,1,6,7,0 -> memwrite exactly 1 cycle, aluop=10 in EXEC, regdst=1 in RWB, icount=2.
REQ-032 SHALL be verified with beq then j: states 0,1,8,0,1,9,0 -> pcwritecond=1/pcsource=01 in BEQ; pcwrite=1/pcsource=10 in JUMP; icount+=2.
REQ-033 SHALL be verified with op=111111: states 0,1,0 -> illegal=1 for exactly the DECODE cycle, icount unchanged, no write strobes.
REQ-034 SHALL be verified with rst_n pulled low mid-MEMRD, asynchronously between edges -> state=0 and icount=0 immediately, memread=0 during reset, FETCH outputs on the first edge after release.
REQ-035 SHALL be verified with icount preloaded to 0xFFFF by running 65535 j instructions, then one more -> icount=0x0000.
